// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle sequencer driving the 4x8 register file.
// Each instruction is fetched from a combinational ROM, decoded (operands
// latched from the register file), executed in an 8-bit ALU and written
// back. HALT stops the sequencer until start is seen again.
//
// start/busy: start is a level that is only looked at while the sequencer
// is parked (IDLE or HALT, busy=0). One sampled start launches execution
// at the current pc. While busy=1 start is ignored. done pulses for one
// cycle when HALT is entered.
module cpu_ctrl #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] pc,
    input  logic [7:0]    instr,
    output logic [1:0]    n1,
    output logic [1:0]    n2,
    input  logic [7:0]    q1,
    input  logic [7:0]    q2,
    output logic [1:0]    nd,
    output logic [7:0]    di,
    output logic          reg_we,
    output logic          busy,
    output logic          done,
    output logic          zero,
    output logic          carry,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    ir_q, ir_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    y_q, y_d;
    logic          zero_q, zero_d;
    logic          carry_q, carry_d;
    logic          done_q, done_d;

    logic          instr_halt;
    logic          ir_halt;
    logic [7:0]    alu_y;
    logic          alu_c;

    // HALT is opcode 11 with rs2 = 11; every other 11 encoding is MOV.
    assign instr_halt = (instr[7:6] == 2'b11) && (instr[1:0] == 2'b11);
    assign ir_halt    = (ir_q[7:6] == 2'b11) && (ir_q[1:0] == 2'b11);

    // State register plus all datapath flops; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            y_q     <= 8'h00;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = ir_halt ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // ALU: 9-bit add/subtract so bit 8 is carry (ADD) or borrow (SUB).
    always_comb begin
        alu_y = 8'h00;
        alu_c = 1'b0;
        case (ir_q[7:6])
            2'b00:   {alu_c, alu_y} = {1'b0, a_q} + {1'b0, b_q};
            2'b01:   {alu_c, alu_y} = {1'b0, a_q} - {1'b0, b_q};
            2'b10:   alu_y = a_q & b_q;
            default: alu_y = a_q;
        endcase
    end

    // Datapath register updates per state; HALT advances pc during its FETCH.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = instr;
                if (instr_halt) pc_d = pc_q + PC_ONE;
            end
            S_DECODE: begin
                a_d    = q1;
                b_d    = q2;
                done_d = ir_halt;
            end
            S_EXEC: begin
                y_d     = alu_y;
                zero_d  = (alu_y == 8'h00);
                carry_d = alu_c;
            end
            S_WB:    pc_d = pc_q + PC_ONE;
            default: ;
        endcase
    end

    // Outputs: register-file ports come straight from ir and y in every state.
    always_comb begin
        pc        = pc_q;
        n1        = ir_q[3:2];
        n2        = ir_q[1:0];
        nd        = ir_q[5:4];
        di        = y_q;
        reg_we    = (state_q == S_WB);
        busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)  || (state_q == S_WB);
        done      = done_q;
        zero      = zero_q;
        carry     = carry_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: drives cpu_ctrl (AW=2) with a small ROM and register file
// model, and checks it against an instruction-level reference model.
module tb_cpu_ctrl;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] pc;
  logic [7:0]    instr;
  logic [1:0]    n1, n2, nd;
  logic [7:0]    q1, q2, di;
  logic          reg_we, busy, done, zero, carry;
  logic [2:0]    state_dbg;

  int checks = 0;
  int fails  = 0;

  // environment: ROM and register file
  logic [7:0] rom [4];
  logic [7:0] rf  [4];

  // reference model state
  logic [7:0] m_rf [4];
  int         m_pc;
  logic       m_zero, m_carry;
  logic [11:0] exp_q[$];   // {carry, zero, nd, di} per expected write

  cpu_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
    .n1(n1), .n2(n2), .q1(q1), .q2(q2), .nd(nd), .di(di),
    .reg_we(reg_we), .busy(busy), .done(done), .zero(zero), .carry(carry),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr = rom[pc];
  assign q1 = rf[n1];
  assign q2 = rf[n2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf[0] <= 8'd11; rf[1] <= 8'd22; rf[2] <= 8'd0; rf[3] <= 8'd0;
    end else if (reg_we) begin
      rf[nd] <= di;
    end
  end

  // scoreboard: every write must match the next expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got nd=%0d di=%0h, required no write", nd, di);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({carry, zero, nd, di} !== e) begin
          fails++;
          $display("FAIL write: got c=%0b z=%0b nd=%0d di=%0h, required c=%0b z=%0b nd=%0d di=%0h",
                   carry, zero, nd, di, e[11], e[10], e[9:8], e[7:0]);
        end
      end
    end
  end

  // reference model: execute instructions from m_pc until HALT
  task automatic model_run(input int max_instr, output int n_exec);
    logic [7:0] ins, a, b, y;
    logic       c;
    int         s;
    n_exec = 0;
    for (int k = 0; k < max_instr; k++) begin
      ins = rom[m_pc];
      if (ins[7:6] == 2'b11 && ins[1:0] == 2'b11) begin
        m_pc = (m_pc + 1) % 4;
        return;
      end
      a = m_rf[ins[3:2]];
      b = m_rf[ins[1:0]];
      case (ins[7:6])
        2'b00: begin s = int'(a) + int'(b); c = (s > 255); y = 8'(s % 256); end
        2'b01: begin c = (a < b); s = int'(a) - int'(b) + 256; y = 8'(s % 256); end
        2'b10: begin y = a & b; c = 1'b0; end
        default: begin y = a; c = 1'b0; end
      endcase
      m_rf[ins[5:4]] = y;
      m_zero  = (y == 8'h00);
      m_carry = c;
      exp_q.push_back({c, (y == 8'h00), ins[5:4], y});
      m_pc = (m_pc + 1) % 4;
      n_exec++;
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    exp_q.delete();
    m_rf[0] = 8'd11; m_rf[1] = 8'd22; m_rf[2] = 8'd0; m_rf[3] = 8'd0;
    m_pc = 0; m_zero = 1'b0; m_carry = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // called at a negedge; cycle 1 is the first cycle after start is sampled
  task automatic run_to_done(input int bound, output int done_cyc,
                             output int we_cnt, output int first_we);
    done_cyc = -1; we_cnt = 0; first_we = -1;
    start = 1'b1;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (reg_we === 1'b1) begin
        we_cnt++;
        if (first_we < 0) first_we = cyc;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc, n1, n2, nd, di} !== '0) begin
      fails++;
      $display("FAIL reset_ports: got pc=%0d n1=%0d n2=%0d nd=%0d di=%0h, required all 0",
               pc, n1, n2, nd, di);
    end
    checks++;
    if ({reg_we, busy, done, zero, carry} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got we/busy/done/z/c=%05b, required 00000",
               {reg_we, busy, done, zero, carry});
    end
  endtask

  task automatic test_add();
    int n, dc, wc, fw;
    do_reset();
    rom[0] = 8'h21; rom[1] = 8'hFF; rom[2] = 8'hFF; rom[3] = 8'hFF;
    model_run(8, n);
    run_to_done(40, dc, wc, fw);
    checks++;
    if (dc !== 7) begin
      fails++; $display("FAIL add_done_cycle: got %0d, required 7", dc);
    end
    checks++;
    if (wc !== 1 || fw !== 4) begin
      fails++; $display("FAIL add_we: got count=%0d first=%0d, required count=1 first=4", wc, fw);
    end
    checks++;
    if (rf[2] !== 8'd33) begin
      fails++; $display("FAIL add_r2: got %0d, required 33", rf[2]);
    end
    checks++;
    if (pc !== 2'd2 || carry !== 1'b0 || zero !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_final: got pc=%0d c=%0b z=%0b busy=%0b, required pc=2 c=0 z=0 busy=0",
               pc, carry, zero, busy);
    end
  endtask

  task automatic test_sub();
    int n, dc, wc, fw;
    do_reset();
    rom[0] = 8'h71; rom[1] = 8'h60; rom[2] = 8'hFF; rom[3] = 8'hFF;
    model_run(8, n);
    run_to_done(40, dc, wc, fw);
    checks++;
    if (dc !== 11 || rf[3] !== 8'hF5 || rf[2] !== 8'h00) begin
      fails++;
      $display("FAIL sub_result: got done=%0d r3=%0h r2=%0h, required done=11 r3=f5 r2=0",
               dc, rf[3], rf[2]);
    end
    checks++;
    if (zero !== 1'b1 || carry !== 1'b0 || pc !== 2'd3) begin
      fails++;
      $display("FAIL sub_final: got z=%0b c=%0b pc=%0d, required z=1 c=0 pc=3", zero, carry, pc);
    end
  endtask

  task automatic test_and_mov();
    int n, dc, wc, fw;
    do_reset();
    rom[0] = 8'h91; rom[1] = 8'hF4; rom[2] = 8'hFF; rom[3] = 8'hFF;
    model_run(8, n);
    run_to_done(40, dc, wc, fw);
    checks++;
    if (rf[1] !== 8'h02 || rf[3] !== 8'h02) begin
      fails++; $display("FAIL and_mov: got r1=%0h r3=%0h, required r1=2 r3=2", rf[1], rf[3]);
    end
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0 || wc !== 2) begin
      fails++;
      $display("FAIL and_mov_flags: got c=%0b z=%0b writes=%0d, required c=0 z=0 writes=2",
               carry, zero, wc);
    end
  endtask

  task automatic test_alias();
    int n, dc, wc, fw;
    do_reset();
    rom[0] = 8'h05; rom[1] = 8'h00; rom[2] = 8'hFF; rom[3] = 8'hFF;
    model_run(8, n);
    run_to_done(40, dc, wc, fw);
    checks++;
    if (rf[0] !== 8'd88 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL alias: got r0=%0d pending=%0d, required r0=88 pending=0", rf[0], exp_q.size());
    end
  endtask

  // start held high: HALT restarts one cycle after it is entered
  task automatic test_back_to_back();
    int n, d1, d2;
    logic busy8;
    do_reset();
    rom[0] = 8'h21; rom[1] = 8'hFF; rom[2] = 8'h05; rom[3] = 8'hFF;
    model_run(8, n);
    model_run(8, n);
    d1 = -1; d2 = -1; busy8 = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 8) busy8 = busy;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 7 || d2 !== 14 || busy8 !== 1'b1) begin
      fails++;
      $display("FAIL start_held: got done at %0d,%0d busy8=%0b, required 7,14 busy8=1", d1, d2, busy8);
    end
    checks++;
    if (rf[0] !== 8'd44 || pc !== 2'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL start_held_state: got r0=%0d pc=%0d pending=%0d, required r0=44 pc=0 pending=0",
               rf[0], pc, exp_q.size());
    end
  endtask

  task automatic test_random();
    int n, dc, wc, fw, h;
    logic [7:0] r;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      h = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        r = 8'($urandom_range(0, 255));
        if (r[7:6] == 2'b11 && r[1:0] == 2'b11) r[1:0] = 2'($urandom_range(0, 2));
        rom[i] = (i == h) ? 8'hFF : r;
      end
      model_run(8, n);
      run_to_done(40, dc, wc, fw);
      checks++;
      if (dc !== 4 * n + 3 || wc !== n) begin
        fails++;
        $display("FAIL rand_timing it=%0d: got done=%0d writes=%0d, required done=%0d writes=%0d",
                 it, dc, wc, 4 * n + 3, n);
      end
      checks++;
      if (pc !== 2'(m_pc) || zero !== m_zero || carry !== m_carry ||
          rf[0] !== m_rf[0] || rf[1] !== m_rf[1] || rf[2] !== m_rf[2] || rf[3] !== m_rf[3]) begin
        fails++;
        $display("FAIL rand_state it=%0d: got pc=%0d z=%0b c=%0b rf=%0h %0h %0h %0h, required pc=%0d z=%0b c=%0b rf=%0h %0h %0h %0h",
                 it, pc, zero, carry, rf[0], rf[1], rf[2], rf[3],
                 m_pc, m_zero, m_carry, m_rf[0], m_rf[1], m_rf[2], m_rf[3]);
      end
    end
  endtask

  // no HALT: pc wraps, mid-run start is ignored, reset lands during an EXEC
  task automatic test_wrap_reset();
    int n, we_seen;
    logic busy10;
    do_reset();
    for (int i = 0; i < 4; i++) rom[i] = 8'h21;
    model_run(6, n);
    busy10 = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) begin busy10 = busy; start = 1'b1; end
      if (cyc == 11) start = 1'b0;
      if (cyc == 25) begin
        checks++;
        if (pc !== 2'd2 || exp_q.size() != 0 || busy10 !== 1'b1) begin
          fails++;
          $display("FAIL wrap: got pc=%0d pending=%0d busy10=%0b, required pc=2 pending=0 busy10=1",
                   pc, exp_q.size(), busy10);
        end
      end
    end
    // cycle 27 is the EXEC of the seventh instruction
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, n1, n2, nd, di, reg_we, busy, done, zero, carry} !== '0) begin
      fails++;
      $display("FAIL reset_mid_exec: got pc=%0d nd=%0d di=%0h we=%0b busy=%0b done=%0b z=%0b c=%0b, required all 0",
               pc, nd, di, reg_we, busy, done, zero, carry);
    end
    we_seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (reg_we === 1'b1) we_seen++;
      if (cyc == 3) rst_n = 1'b1;
    end
    checks++;
    if (we_seen !== 0 || rf[2] !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_partial_write: got writes=%0d r2=%0d busy=%0b, required 0 0 0",
               we_seen, rf[2], busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 8'hFF;
    test_reset();
    test_add();
    test_sub();
    test_and_mov();
    test_alias();
    test_back_to_back();
    test_random();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
